// File: rtl/phase_freq_detector.sv
// Signed reference-vs-generated edge offset detector for the ADPLL loop, with
// count saturation, cycle-slip detection, power-of-two averaging and lock flag.
module phase_freq_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 2,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    reference_i,
    input  logic                    generated_i,
    output logic signed [WIDTH-1:0] pd_clock_cycles_o,
    output logic                    pd_valid_o,
    output logic                    saturated_o,
    output logic                    slip_o,
    output logic                    locked_o
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic signed [WIDTH-1:0] CNT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] CNT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
    localparam logic [LCK_W-1:0]        LCK_FULL = LCK_W'(LOCK_COUNT);
    localparam logic [WIDTH:0]          THR      = (WIDTH+1)'(LOCK_THRESH);

    typedef enum logic [1:0] {IDLE, REF_LEAD, GEN_LEAD} state_t;

    function automatic logic signed [WIDTH-1:0] sat_inc(input logic signed [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_dec(input logic signed [WIDTH-1:0] v);
        return (v == CNT_MIN) ? v : v - ONE;
    endfunction

    // Magnitude needs one extra bit so that the most negative value is representable.
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        return (e < 0) ? -e : e;
    endfunction

    logic [SYNC_STAGES-1:0]    ref_sync_q, ref_sync_d, gen_sync_q, gen_sync_d;
    logic                      ref_prev_q, ref_prev_d, gen_prev_q, gen_prev_d;
    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WIN_W-1:0]          win_q, win_d;
    logic                      sat_flag_q, sat_flag_d;
    logic signed [WIDTH-1:0]   pd_q, pd_d;
    logic                      valid_q, valid_d, sat_q, sat_d, slip_q, slip_d;
    logic [LCK_W-1:0]          lock_cnt_q, lock_cnt_d;
    logic                      locked_q, locked_d;

    logic                      ref_edge, gen_edge, res_vld, res_sat;
    logic signed [WIDTH-1:0]   res;
    logic signed [ACC_W-1:0]   acc_sum;

    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], reference_i};
        gen_sync_d = {gen_sync_q[SYNC_STAGES-2:0], generated_i};
        ref_prev_d = ref_sync_q[SYNC_STAGES-1];
        gen_prev_d = gen_sync_q[SYNC_STAGES-1];
        ref_edge   = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
        gen_edge   = gen_sync_q[SYNC_STAGES-1] & ~gen_prev_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        win_d      = win_q;
        sat_flag_d = sat_flag_q;
        pd_d       = pd_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;
        slip_d     = 1'b0;
        lock_cnt_d = lock_cnt_q;
        res_vld    = 1'b0;
        res_sat    = 1'b0;
        res        = '0;

        if (!enable_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            acc_d      = '0;
            win_d      = '0;
            sat_flag_d = 1'b0;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ref_edge && gen_edge) begin
                        res_vld = 1'b1;
                    end else if (ref_edge) begin
                        state_d = REF_LEAD;
                        cnt_d   = '0;
                    end else if (gen_edge) begin
                        state_d = GEN_LEAD;
                        cnt_d   = '0;
                    end
                end
                REF_LEAD: begin
                    if (gen_edge) begin
                        res_vld = 1'b1;
                        res     = sat_inc(cnt_q);
                        res_sat = (cnt_q == CNT_MAX);
                        cnt_d   = '0;
                        state_d = ref_edge ? REF_LEAD : IDLE;
                    end else if (ref_edge) begin
                        slip_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                GEN_LEAD: begin
                    if (ref_edge) begin
                        res_vld = 1'b1;
                        res     = sat_dec(cnt_q);
                        res_sat = (cnt_q == CNT_MIN);
                        cnt_d   = '0;
                        state_d = gen_edge ? GEN_LEAD : IDLE;
                    end else if (gen_edge) begin
                        slip_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = sat_dec(cnt_q);
                    end
                end
                default: state_d = IDLE;
            endcase

            acc_sum = acc_q + ACC_W'(res);
            if (res_vld) begin
                if (win_q == WIN_LAST) begin
                    pd_d       = WIDTH'(acc_sum >>> AVG_LOG2);
                    sat_d      = sat_flag_q | res_sat;
                    valid_d    = 1'b1;
                    acc_d      = '0;
                    win_d      = '0;
                    sat_flag_d = 1'b0;
                end else begin
                    acc_d      = acc_sum;
                    win_d      = win_q + WIN_W'(1);
                    sat_flag_d = sat_flag_q | res_sat;
                end
            end

            // Lock qualification looks at the result currently on the outputs.
            if (slip_q) begin
                lock_cnt_d = '0;
            end else if (valid_q) begin
                if (mag(pd_q) <= THR && !sat_q)
                    lock_cnt_d = (lock_cnt_q == LCK_FULL) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);
                else
                    lock_cnt_d = '0;
            end
        end
        acc_sum  = acc_q + ACC_W'(res);
        locked_d = (lock_cnt_d == LCK_FULL);
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_sync_q <= '0;
            gen_sync_q <= '0;
            ref_prev_q <= 1'b0;
            gen_prev_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            win_q      <= '0;
            sat_flag_q <= 1'b0;
            pd_q       <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
            slip_q     <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            ref_sync_q <= ref_sync_d;
            gen_sync_q <= gen_sync_d;
            ref_prev_q <= ref_prev_d;
            gen_prev_q <= gen_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            win_q      <= win_d;
            sat_flag_q <= sat_flag_d;
            pd_q       <= pd_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
            slip_q     <= slip_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign pd_clock_cycles_o = pd_q;
    assign pd_valid_o        = valid_q;
    assign saturated_o       = sat_q;
    assign slip_o            = slip_q;
    assign locked_o          = locked_q;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Bench for phase_freq_detector: three parameterisations share one stimulus and
// are compared each cycle against an edge-timestamp model, plus directed tables.
module tb_phase_freq_detector;
    localparam int SYNC = 2;
    localparam int LT   = 2;
    localparam int LC   = 8;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, ref_i = 1'b0, gen_i = 1'b0;
    logic signed [7:0] pd_a, pd_v;
    logic signed [3:0] pd_w;
    logic va, sa, sla, la, vw, sw, slw, lw, vv, sv, slv, lv;

    int checks = 0, failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    phase_freq_detector #(.WIDTH(8), .SYNC_STAGES(SYNC), .AVG_LOG2(0), .LOCK_THRESH(LT), .LOCK_COUNT(LC)) u_a (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .reference_i(ref_i), .generated_i(gen_i),
        .pd_clock_cycles_o(pd_a), .pd_valid_o(va), .saturated_o(sa), .slip_o(sla), .locked_o(la));
    phase_freq_detector #(.WIDTH(4), .SYNC_STAGES(SYNC), .AVG_LOG2(0), .LOCK_THRESH(LT), .LOCK_COUNT(LC)) u_w (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .reference_i(ref_i), .generated_i(gen_i),
        .pd_clock_cycles_o(pd_w), .pd_valid_o(vw), .saturated_o(sw), .slip_o(slw), .locked_o(lw));
    phase_freq_detector #(.WIDTH(8), .SYNC_STAGES(SYNC), .AVG_LOG2(2), .LOCK_THRESH(LT), .LOCK_COUNT(LC)) u_v (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .reference_i(ref_i), .generated_i(gen_i),
        .pd_clock_cycles_o(pd_v), .pd_valid_o(vv), .saturated_o(sv), .slip_o(slv), .locked_o(lv));

    // Model: remembers which input led and when; results are timestamp differences.
    typedef struct {
        bit [10:0] rh, gh;
        int lead, t, wsum, wcnt;
        bit wsat;
        int lock_cnt, pd;
        bit sat, valid, slip, locked;
    } mdl_t;

    mdl_t ma, mw, mv;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.rh = '0; m.gh = '0; m.lead = 0; m.t = 0; m.wsum = 0; m.wcnt = 0; m.wsat = 0;
        m.lock_cnt = 0; m.pd = 0; m.sat = 0; m.valid = 0; m.slip = 0; m.locked = 0;
        return m;
    endfunction

    function automatic int floor_div(int s, int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int n, bit r_in, bit g_in, bit e, int width, int avg);
        mdl_t o;
        bit rp, gp, have, rs;
        int d, res, mx, mn, nwin, apd;
        o = m;
        rp = m.rh[SYNC-1] & ~m.rh[SYNC];
        gp = m.gh[SYNC-1] & ~m.gh[SYNC];
        o.rh = {m.rh[9:0], r_in};
        o.gh = {m.gh[9:0], g_in};
        mx = (1 << (width - 1)) - 1;
        mn = -(1 << (width - 1));
        nwin = 1 << avg;
        o.valid = 0; o.slip = 0; have = 0; rs = 0; res = 0;
        if (!e) begin
            o.lead = 0; o.wsum = 0; o.wcnt = 0; o.wsat = 0; o.lock_cnt = 0; o.locked = 0;
            return o;
        end
        if (m.lead == 0) begin
            if (rp && gp) have = 1;
            else if (rp) begin o.lead = 1; o.t = n; end
            else if (gp) begin o.lead = -1; o.t = n; end
        end else if (m.lead == 1) begin
            if (gp) begin
                d = n - m.t; res = (d > mx) ? mx : d; rs = (d > mx); have = 1;
                if (rp) o.t = n; else o.lead = 0;
            end else if (rp) begin o.slip = 1; o.t = n; end
        end else begin
            if (rp) begin
                d = n - m.t; res = (-d < mn) ? mn : -d; rs = (-d < mn); have = 1;
                if (gp) o.t = n; else o.lead = 0;
            end else if (gp) begin o.slip = 1; o.t = n; end
        end
        if (have) begin
            o.wsum = o.wsum + res; o.wcnt = o.wcnt + 1; o.wsat = o.wsat | rs;
            if (o.wcnt == nwin) begin
                o.pd = floor_div(o.wsum, nwin); o.sat = o.wsat; o.valid = 1;
                o.wsum = 0; o.wcnt = 0; o.wsat = 0;
            end
        end
        apd = (m.pd < 0) ? -m.pd : m.pd;
        if (m.slip) o.lock_cnt = 0;
        else if (m.valid) o.lock_cnt = (apd <= LT && !m.sat) ? ((m.lock_cnt >= LC) ? LC : m.lock_cnt + 1) : 0;
        o.locked = (o.lock_cnt == LC);
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_reset(); mw <= mdl_reset(); mv <= mdl_reset(); cyc <= 0;
        end else begin
            ma <= mdl_step(ma, cyc, ref_i, gen_i, en, 8, 0);
            mw <= mdl_step(mw, cyc, ref_i, gen_i, en, 4, 0);
            mv <= mdl_step(mv, cyc, ref_i, gen_i, en, 8, 2);
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input string nm, input int pd, input bit s, input bit v,
                            input bit sl, input bit lk, input mdl_t m);
        chk({nm, ".pd"}, pd, m.pd);
        chk({nm, ".sat"}, int'(s), int'(m.sat));
        chk({nm, ".valid"}, int'(v), int'(m.valid));
        chk({nm, ".slip"}, int'(sl), int'(m.slip));
        chk({nm, ".locked"}, int'(lk), int'(m.locked));
    endtask

    always @(negedge clk) begin
        cmp_inst("mdl_a", int'(pd_a), sa, va, sla, la, ma);
        cmp_inst("mdl_w", int'(pd_w), sw, vw, slw, lw, mw);
        cmp_inst("mdl_v", int'(pd_v), sv, vv, slv, lv, mv);
    end

    int last_pa, last_pw, last_pv, n_va, n_vv, n_slip;
    bit last_sa, last_sw;

    task automatic sample_outs();
        if (va) begin n_va++; last_pa = int'(pd_a); last_sa = sa; end
        if (vw) begin last_pw = int'(pd_w); last_sw = sw; end
        if (vv) begin n_vv++; last_pv = int'(pd_v); end
        if (sla) n_slip++;
    endtask

    // One measurement: d>0 reference rises d cycles before generated, d<0 the reverse.
    task automatic run_meas(input int d);
        int lead, ra, ga;
        lead = (d < 0) ? -d : d;
        ra = (d >= 0) ? 0 : lead;
        ga = (d >= 0) ? lead : 0;
        n_va = 0; n_vv = 0; n_slip = 0;
        for (int c = 0; c < lead + 20; c++) begin
            @(negedge clk);
            sample_outs();
            ref_i = (c >= ra && c < lead + 6);
            gen_i = (c >= ga && c < lead + 6);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
    endtask

    typedef struct { int d; int exp_a; int exp_w; bit sat_w; } vec_t;
    vec_t tbl[10];

    initial begin
        int tot;
        bit slip_seen;
        tbl[0] = '{5, 5, 5, 1'b0};
        tbl[1] = '{-3, -3, -3, 1'b0};
        tbl[2] = '{0, 0, 0, 1'b0};
        tbl[3] = '{20, 20, 7, 1'b1};
        tbl[4] = '{2, 2, 2, 1'b0};
        tbl[5] = '{-20, -20, -8, 1'b1};
        tbl[6] = '{8, 8, 7, 1'b1};
        tbl[7] = '{7, 7, 7, 1'b0};
        tbl[8] = '{-8, -8, -8, 1'b0};
        tbl[9] = '{-9, -9, -8, 1'b1};

        @(negedge clk);
        chk("rst_pd", int'(pd_a), 0);
        chk("rst_valid", int'(va), 0);
        chk("rst_locked", int'(la), 0);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            run_meas(tbl[i].d);
            chk("tbl_valid_count", n_va, 1);
            chk("tbl_pd_a", last_pa, tbl[i].exp_a);
            chk("tbl_sat_a", int'(last_sa), 0);
            chk("tbl_pd_w", last_pw, tbl[i].exp_w);
            chk("tbl_sat_w", int'(last_sw), int'(tbl[i].sat_w));
        end

        do_reset();
        tot = 0;
        run_meas(3); tot += n_vv;
        run_meas(4); tot += n_vv;
        run_meas(-1); tot += n_vv;
        run_meas(-3); tot += n_vv;
        chk("avg1_valid_count", tot, 1);
        chk("avg1_pd", last_pv, 0);
        tot = 0;
        run_meas(-1); tot += n_vv;
        run_meas(-1); tot += n_vv;
        run_meas(-1); tot += n_vv;
        run_meas(0); tot += n_vv;
        chk("avg2_valid_count", tot, 1);
        chk("avg2_pd", last_pv, -1);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_meas(1);
            if (k == 6) chk("lock_after7", int'(la), 0);
        end
        chk("lock_after8", int'(la), 1);
        run_meas(3);
        chk("unlock_on_3", int'(la), 0);
        for (int k = 0; k < 8; k++) run_meas(1);
        chk("relock", int'(la), 1);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("dis_locked", int'(la), 0);
        chk("dis_pd_hold", int'(pd_a), 1);
        chk("dis_valid", int'(va), 0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) run_meas(1);
        chk("relock2", int'(la), 1);

        n_va = 0; n_slip = 0; slip_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (slip_seen) begin
                chk("slip_unlock", int'(la), 0);
                slip_seen = 0;
            end
            if (sla) slip_seen = 1;
            sample_outs();
            ref_i = (c < 3) || (c >= 10 && c < 13);
            gen_i = (c >= 14 && c < 17);
        end
        chk("slip_count", n_slip, 1);
        chk("slip_valid_count", n_va, 1);
        chk("slip_result", last_pa, 4);
        chk("slip_locked", int'(la), 0);

        @(negedge clk);
        ref_i = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_pd", int'(pd_a), 0);
        chk("amid_rst_valid", int'(va), 0);
        chk("amid_rst_locked", int'(la), 0);
        chk("amid_rst_slip", int'(sla), 0);
        @(negedge clk);
        ref_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 120; k++) begin
            run_meas(int'($urandom_range(0, 50)) - 25);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                en = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                en = 1'b1;
            end
        end
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                ref_i = ($urandom_range(0, 3) == 0);
                gen_i = ($urandom_range(0, 3) == 0);
                en = ($urandom_range(0, 15) != 0);
            end
            @(negedge clk);
            ref_i = 1'b0; gen_i = 1'b0; en = 1'b1;
            repeat (10) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phase_freq_detector.md
Name: phase_freq_detector

Overview:
Parametrised successor to the single-shot up/down-counter phase detector in the ADPLL loop. It measures signed reference-to-generated edge offset in fpga_clk_i cycles, with saturation, cycle-slip (frequency) detection, power-of-two result averaging and a lock indicator. It sits between the input synchronisation and the loop filter, and feeds the DCO control path.

Parameters:
WIDTH, 8, width of signed result and internal counter (two's complement)
SYNC_STAGES, 2, flops per input synchroniser (min 2)
AVG_LOG2, 2, results averaged = 2^AVG_LOG2 (0 = no averaging)
LOCK_THRESH, 2, max |result| counted as in-lock
LOCK_COUNT, 8, consecutive in-lock results needed to assert locked_o (min 1)

Ports:
fpga_clk_i  in  1  system clock; the only clock
reset_i  in  1  asynchronous reset, active-high
enable_i  in  1  measurement enable
reference_i  in  1  asynchronous reference clock
generated_i  in  1  asynchronous DCO output
pd_clock_cycles_o  out  WIDTH  signed averaged phase error; positive = reference leads
pd_valid_o  out  1  one-cycle pulse when pd_clock_cycles_o updates
saturated_o  out  1  result included a saturated measurement
slip_o  out  1  one-cycle pulse on cycle slip
locked_o  out  1  loop lock indicator

Behaviour:
- Reset (async, reset_i=1): all outputs 0, FSM IDLE, counter/accumulator/lock count 0, sync flops 0.
- Inputs pass SYNC_STAGES flops, then rising-edge detect (1-cycle pulse per edge).
- FSM states: IDLE, REF_LEAD (count up), GEN_LEAD (count down).
  - IDLE:
    - ref only -> REF_LEAD, cnt=0.
    - gen only -> GEN_LEAD, cnt=0.
    - both same cycle -> raw result 0, stay IDLE.
  - REF_LEAD: cnt+1 each cycle.
    - gen edge -> raw result = cnt+1 and close measurement.
      - If a ref edge is in the same cycle, go to REF_LEAD with cnt=0 (new measurement).
      - Otherwise go to IDLE.
    - ref edge with no gen edge -> slip_o pulse, cnt=0, stay REF_LEAD.
  - GEN_LEAD: mirror of REF_LEAD, counting down; raw result = cnt-1 (negative).
- Raw result = signed cycle distance between the two detected edges. Example: ref edge at cycle a, gen edge at a+5 -> +5.
- Saturation: cnt clamps at +(2^(WIDTH-1)-1) and -2^(WIDTH-1) and holds there, with no wrap. Any raw result from a clamped count sets a sticky sat flag for the current averaging window.
- Averaging:
  - Accumulator is WIDTH+AVG_LOG2 bits signed; it sums 2^AVG_LOG2 raw results.
  - On the last result, pd_clock_cycles_o = accumulator >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
  - Same cycle: saturated_o = sat flag, pd_valid_o = 1; accumulator and sat flag then clear.
  - Outputs hold between updates.
  - AVG_LOG2=0 passes each raw result straight through.
- Latency: output registered 1 cycle after the closing edge-detect pulse.
- Lock:
  - On each pd_valid_o: if |output| <= LOCK_THRESH and saturated_o=0, lock_cnt increments, saturating at LOCK_COUNT; otherwise lock_cnt=0.
  - locked_o = (lock_cnt == LOCK_COUNT), registered. It therefore asserts the cycle after the LOCK_COUNT-th in-lock pd_valid_o.
  - An out-of-lock pd_valid_o clears locked_o on the next cycle.
  - Any slip_o pulse clears lock_cnt and locked_o on the next cycle.
- enable_i=0:
  - FSM forced to IDLE; cnt, accumulator, window count, sat flag and lock_cnt cleared; locked_o=0.
  - pd_clock_cycles_o and saturated_o hold; pd_valid_o and slip_o are 0.
  - Synchronisers keep running, so re-enable produces no spurious edge.
- Reset mid-measurement discards partial results immediately (async).

Test Plan:
- AVG_LOG2=0; ref edge, gen edge 5 cycles later, repeated -> pd_clock_cycles_o=+5, pd_valid_o single pulse per period, 1 cycle after gen edge-detect; saturated_o=0.
- AVG_LOG2=0; gen leads by 3, then edges simultaneous -> -3, then 0 with valid pulses.
- WIDTH=4; ref leads by 20 cycles -> output +7, saturated_o=1. Next measurement at +2 -> output +2, saturated_o=0.
- Two ref edges 10 cycles apart, no gen edge, then gen 4 cycles after the second ref -> slip_o pulse at the second ref, result +4, locked_o forced 0.
- AVG_LOG2=2; results +3,+4,-1,-3 -> one valid with floor(3/4)=0. Results -1,-1,-1,0 -> floor(-3/4)=-1.
- LOCK_COUNT=8, LOCK_THRESH=2:
  - eight results of +1 -> locked_o=1 after the 8th valid.
  - then a +3 result -> locked_o=0 next cycle.
  - enable_i low -> locked_o=0 and outputs held.
  - reset_i pulse mid-count -> all outputs 0 immediately.
